linear_ramp_gen: RTL and testbench
==================================

Name: linear_ramp_gen

Overview:
- Stage directly downstream of gen_delta: consumes its fixed-point slope `delta` (DT_I.DT_D, unsigned) and a base level.
- Emits X_DISPLACEMENT interpolated samples y_i = y_base + i*delta on a valid/ready stream.
- Fills the line segment between two control points for the linear-transformation datapath.
- Fractional bits accumulate across steps; the output is truncated to DSIZE integer bits and saturates at the top.

Parameters:
- X_DISPLACEMENT, 16: samples per segment; must be >= 2. Same value as the gen_delta instance that feeds this block.
- DSIZE, 16: integer sample width.
- DT_I, 8: integer bits of delta.
- DT_D, 4: fractional bits of delta.
- IW, $clog2(X_DISPLACEMENT) (localparam): index width.

Ports:
- clock, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: request a new segment; accepted only when busy==0.
- y_base, input, DSIZE: first sample value; sampled on accept.
- delta, input, DT_I+DT_D: slope from gen_delta; sampled on accept.
- abort, input, 1: synchronous cancel of the running segment.
- busy, output, 1: segment in progress.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the beat.
- out_data, output, DSIZE: current sample.
- out_index, output, IW: index i of the current sample.
- out_last, output, 1: high with the beat where i == X_DISPLACEMENT-1.
- done, output, 1: one-cycle pulse after the last beat transfers.

Behaviour:
- Reset: asynchronous, active-low (rst_n). While rst_n is low, all outputs are 0, state = IDLE, accumulator = 0, sat flag = 0.
- Reset mid-segment: state returns to IDLE immediately. No done pulse is issued.
- States: IDLE and RUN.
- IDLE, on start=1:
  - acc <= {1'b0, y_base, DT_D'b0}; acc width is DSIZE+DT_D+1.
  - d_reg <= delta.
  - idx <= 0, sat <= 0, next state RUN.
  - busy and out_valid rise on the following cycle, so the first beat is visible 1 cycle after accept.
- RUN:
  - out_valid = 1.
  - out_data = sat ? all-ones : acc[DT_D +: DSIZE].
  - out_index = idx.
  - out_last = (idx == X_DISPLACEMENT-1).
- Beat transfer (out_valid && out_ready):
  - If out_last: go to IDLE; done = 1 for that next cycle; busy and out_valid drop on that same cycle.
  - Otherwise: idx <= idx+1 and acc <= acc + zero-extended d_reg.
  - If the sum's MSB (bit DSIZE+DT_D) sets, sat <= 1. sat is sticky until the next accept.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable. No accumulation occurs.
- Arithmetic:
  - delta is aligned so its DT_D fraction bits line up with acc[DT_D-1:0].
  - The integer part adds into acc[DT_D+:DT_I]; the upper bits are zero-extended.
  - Truncation only, no rounding.
- start while busy=1: ignored. This includes start in the same cycle as the final beat transfer; a new segment can be accepted the cycle after, when done=1 and busy=0.
- abort=1 in RUN: go to IDLE next cycle and clear out_valid. No done pulse. abort has priority over a simultaneous beat transfer. abort in IDLE has no effect.
- Upstream timing: gen_delta has 2-cycle latency. The sequencer asserts start no earlier than 2 cycles after y_displacement is stable; this block does not check it.
- Throughput: 1 sample/cycle with out_ready held high. Segment occupancy is X_DISPLACEMENT cycles plus 1 cycle for the done pulse.

Decomposition:
- Shared package lt_pkg holds:
  - state enum {IDLE, RUN}
  - function ramp_acc_w(DSIZE, DT_D) = DSIZE+DT_D+1
  - the delta format constants DT_I and DT_D, so gen_delta and this block agree on the format.
- One natural sub-module, ramp_accum: the accumulator plus saturation flag, with load/step enables and a saturated DSIZE output. The FSM, index counter and handshake stay in linear_ramp_gen.

Test Plan:
1. Integer slope: y_base=100, delta=12'h010 (1.0), out_ready=1 -> out_data 100..115 on consecutive cycles; out_last on 115 with out_index=15; done pulses 1 cycle later.
2. Fractional slope: y_base=100, delta=12'h008 (0.5) -> 100,100,101,101,...,107,107; out_last on the second 107.
3. Saturation: y_base=16'hFFF0, delta=12'h020 (2.0) -> FFF0, FFF2, ..., FFFE (indices 0..7), then FFFF for indices 8..15; the sat flag clears on the next start.
4. Backpressure: as test 1, with out_ready toggling 1,0,0,1,... -> output held during the 0 cycles; the sequence is still exactly 100..115 with no duplicates or skips.
5. Control races:
   - start during RUN -> ignored; the segment completes unchanged.
   - start in the done cycle -> new segment, first beat 1 cycle later.
   - abort at index 5 -> out_valid=0 next cycle, no done pulse, busy=0.
6. Reset mid-segment: drop rst_n at index 7 -> all outputs 0 asynchronously. After release, a new start with y_base=0, delta=12'hFFF -> sequence 0, 255, 511, ... (truncated from the 255.9375 step).

Source files
------------

// File: rtl/lt_pkg.sv
// Shared types and delta-format constants for the linear-transformation datapath.
// gen_delta and linear_ramp_gen both take their slope format from here.
package lt_pkg;

  localparam int DT_I = 8;
  localparam int DT_D = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One guard bit above the integer field detects overflow out of DSIZE.
  function automatic int ramp_acc_w(input int dsize, input int dt_d);
    return dsize + dt_d + 1;
  endfunction

endpackage

// File: rtl/linear_ramp_gen_ramp_accum.sv
// Fixed-point ramp accumulator with a sticky saturation flag.
// Produces the truncated, top-clamped integer sample for linear_ramp_gen.
module ramp_accum #(
  parameter int DSIZE = 16,
  parameter int DT_I  = lt_pkg::DT_I,
  parameter int DT_D  = lt_pkg::DT_D
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [DSIZE-1:0]     y_base,
  input  logic [DT_I+DT_D-1:0] delta,
  output logic [DSIZE-1:0]     sample
);
  import lt_pkg::*;

  localparam int ACC_W = ramp_acc_w(DSIZE, DT_D);

  logic [ACC_W-1:0]     acc_reg;
  logic [ACC_W-1:0]     acc_next;
  logic [DT_I+DT_D-1:0] d_reg;
  logic                 sat_reg;

  // Slope fraction lines up with the accumulator fraction; upper bits zero-extended.
  assign acc_next = acc_reg + {{(ACC_W-DT_I-DT_D){1'b0}}, d_reg};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      d_reg   <= '0;
      sat_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= {1'b0, y_base, {DT_D{1'b0}}};
      d_reg   <= delta;
      sat_reg <= 1'b0;
    end else if (step) begin
      acc_reg <= acc_next;
      if (acc_next[ACC_W-1]) begin
        sat_reg <= 1'b1;
      end
    end
  end

  assign sample = sat_reg ? {DSIZE{1'b1}} : acc_reg[DT_D +: DSIZE];

endmodule

// File: rtl/linear_ramp_gen.sv
// Emits X_DISPLACEMENT samples y_i = y_base + i*delta on a valid/ready stream,
// filling the segment between two control points.
module linear_ramp_gen #(
  parameter  int X_DISPLACEMENT = 16,
  parameter  int DSIZE          = 16,
  parameter  int DT_I           = lt_pkg::DT_I,
  parameter  int DT_D           = lt_pkg::DT_D,
  localparam int IW             = $clog2(X_DISPLACEMENT)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DSIZE-1:0]     y_base,
  input  logic [DT_I+DT_D-1:0] delta,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DSIZE-1:0]     out_data,
  output logic [IW-1:0]        out_index,
  output logic                 out_last,
  output logic                 done
);
  import lt_pkg::*;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic            done_reg;
  logic [DSIZE-1:0] sample;

  logic is_run;
  logic is_last;
  logic accept;
  logic xfer;
  logic step;

  assign is_run  = (state_reg == RUN);
  assign is_last = is_run && (idx_reg == IW'(X_DISPLACEMENT - 1));
  assign accept  = !is_run && start;
  // abort wins over a beat presented in the same cycle
  assign xfer    = is_run && out_ready && !abort;
  assign step    = xfer && !is_last;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (xfer) begin
            if (is_last) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  ramp_accum #(
    .DSIZE (DSIZE),
    .DT_I  (DT_I),
    .DT_D  (DT_D)
  ) u_accum (
    .clock  (clock),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (step),
    .y_base (y_base),
    .delta  (delta),
    .sample (sample)
  );

  assign busy      = is_run;
  assign out_valid = is_run;
  assign out_data  = is_run ? sample : '0;
  assign out_index = is_run ? idx_reg : '0;
  assign out_last  = is_last;
  assign done      = done_reg;

endmodule

// File: tb/tb_linear_ramp_gen.sv
// Scoreboard bench for linear_ramp_gen: accepted segments are expanded into expected
// beats by an arithmetic reference; a negedge monitor compares every presented beat.
module tb_linear_ramp_gen;
  localparam int X     = 16;
  localparam int DSIZE = 16;
  localparam int DT_I  = 8;
  localparam int DT_D  = 4;
  localparam int IW    = $clog2(X);
  localparam longint unsigned MAXV = (64'd1 << DSIZE) - 1;

  typedef struct {
    logic [DSIZE-1:0] data;
    logic [IW-1:0]    idx;
    logic             last;
  } beat_t;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [DSIZE-1:0]     y_base = '0;
  logic [DT_I+DT_D-1:0] delta = '0;
  logic                 abort = 1'b0;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DSIZE-1:0]     out_data;
  logic [IW-1:0]        out_index;
  logic                 out_last;
  logic                 done;

  int    n_checks = 0;
  int    n_err    = 0;
  int    ready_mode = 0;
  int    accept_cnt = 0;
  beat_t exp_q[$];
  logic  model_busy = 1'b0;
  logic  done_exp   = 1'b0;

  linear_ramp_gen #(
    .X_DISPLACEMENT (X),
    .DSIZE          (DSIZE),
    .DT_I           (DT_I),
    .DT_D           (DT_D)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .y_base    (y_base),
    .delta     (delta),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: y_i = floor(y_base + i*delta), clamped to the DSIZE maximum.
  task automatic push_segment(input logic [DSIZE-1:0] yb, input logic [DT_I+DT_D-1:0] d);
    for (int i = 0; i < X; i++) begin
      longint unsigned v;
      beat_t b;
      v = ((longint'(yb) << DT_D) + longint'(i) * longint'(d)) >> DT_D;
      if (v > MAXV) v = MAXV;
      b.data = v[DSIZE-1:0];
      b.idx  = IW'(i);
      b.last = (i == X - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      model_busy = 1'b0;
      done_exp   = 1'b0;
    end else begin
      logic b;
      b = model_busy;
      chk("busy", busy, b);
      chk("out_valid", out_valid, b);
      chk("done", done, done_exp);
      done_exp = 1'b0;
      if (!b) begin
        if (start) begin
          push_segment(y_base, delta);
          model_busy = 1'b1;
          accept_cnt++;
        end
      end else if (exp_q.size() == 0) begin
        chk("underrun", 1, 0);
      end else begin
        beat_t e;
        e = exp_q[0];
        chk("out_data", out_data, e.data);
        chk("out_index", out_index, e.idx);
        chk("out_last", out_last, e.last);
        if (abort) begin
          exp_q.delete();
          model_busy = 1'b0;
        end else if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.last) begin
            model_busy = 1'b0;
            done_exp   = 1'b1;
          end
        end
      end
    end
  end

  // Ready pattern generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  initial begin
    int rcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       out_ready = (rcnt % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      rcnt++;
    end
  end

  task automatic issue(input logic [DSIZE-1:0] yb, input logic [DT_I+DT_D-1:0] d);
    @(posedge clock);
    #1;
    start  = 1'b1;
    y_base = yb;
    delta  = d;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((model_busy || exp_q.size() != 0) && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 400) chk("idle_timeout", 1, 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic wait_index(input int k);
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(out_valid && out_index == IW'(k)) && n < 200);
    if (n >= 200) chk("index_timeout", 1, 0);
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", done, 0);
    @(posedge clock);
    #2 rst_n = 1'b1;

    // integer, fractional, saturating slopes
    issue(16'd100, 12'h010); wait_idle(); $display("seg int slope done");
    issue(16'd100, 12'h008); wait_idle(); $display("seg frac slope done");
    issue(16'hFFF0, 12'h020); wait_idle(); $display("seg saturate done");
    issue(16'd100, 12'h010); wait_idle(); $display("seg after saturate done");

    // backpressure
    ready_mode = 1;
    issue(16'd100, 12'h010); wait_idle(); $display("seg backpressure done");
    ready_mode = 0;

    // start while running is ignored
    issue(16'd100, 12'h010);
    repeat (3) @(posedge clock);
    #1 start = 1'b1; y_base = 16'd7; delta = 12'h030;
    @(posedge clock);
    #1 start = 1'b0;
    wait_idle();
    chk("ignored_start_accepts", accept_cnt, 6);
    $display("seg start-while-busy done");

    // start held across the final beat: accepted only in the done cycle
    begin
      int base, n;
      base = accept_cnt;
      n = 0;
      @(posedge clock);
      #1 start = 1'b1; y_base = 16'd200; delta = 12'h010;
      while (accept_cnt < base + 2 && n < 100) begin
        @(posedge clock);
        #1;
        n++;
      end
      start = 1'b0;
      chk("held_start_accepts", accept_cnt, base + 2);
      wait_idle();
      $display("seg back-to-back done");
    end

    // abort at index 5
    issue(16'd100, 12'h010);
    wait_index(5);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clock);
    #1 $display("seg abort done");

    // asynchronous reset at index 7
    issue(16'd100, 12'h010);
    wait_index(7);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(posedge clock);
    #2 rst_n = 1'b1;
    issue(16'd0, 12'hFFF); wait_idle(); $display("seg after reset done");

    // randomized segments
    for (int s = 0; s < 24; s++) begin
      logic [DSIZE-1:0]     yb;
      logic [DT_I+DT_D-1:0] d;
      yb = DSIZE'($urandom);
      if ($urandom_range(0, 2) == 0) yb = 16'hF000 | yb;
      d = (DT_I+DT_D)'($urandom);
      ready_mode = $urandom_range(0, 2);
      issue(yb, d);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
      end
      wait_idle();
      $display("seg rand %0d y_base=%0h delta=%0h ready_mode=%0d", s, yb, d, ready_mode);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
